// File: rtl/fold_output_collector.sv
// Output collector for a folded datapath: tracks the fold-phase sequence, locks onto it,
// and captures the completed sample on the capture phase while locked.
module fold_output_collector #(
    parameter int          DW            = 16,
    parameter int unsigned CAPTURE_PHASE = 2,
    parameter int unsigned LOCK_CNT      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    count,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] y_out,
    output logic          y_valid,
    output logic          locked,
    output logic          phase_err,
    output logic [7:0]    err_cnt
);

    localparam int unsigned RunW      = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [RunW-1:0] LockRun  = RunW'(LOCK_CNT);
    localparam logic [RunW-1:0] RunOne   = RunW'(1);
    localparam logic [1:0]      CapPhase = 2'(CAPTURE_PHASE);

    typedef enum logic [1:0] {
        StHunt,
        StAcq,
        StLocked
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      exp_q, exp_d;
    logic [RunW-1:0] run_q, run_d;
    logic [RunW-1:0] run_inc;
    logic [DW-1:0]   y_out_q;
    logic            y_valid_q;
    logic            locked_q;
    logic            phase_err_q;
    logic [7:0]      err_cnt_q;

    logic            in_seq;
    logic            capture;
    logic            err_evt;
    state_e          restart_state;
    logic [1:0]      restart_exp;
    logic [RunW-1:0] restart_run;

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // exp only ever holds 0..2, so count==3 can never be in sequence.
    assign in_seq  = (count == exp_q);
    assign run_inc = run_q + RunOne;

    // A broken sequence restarts acquisition in place if it lands on phase 0.
    always_comb begin
        restart_state = StHunt;
        restart_exp   = 2'd0;
        restart_run   = '0;
        if (count == 2'd0) begin
            restart_state = StAcq;
            restart_exp   = 2'd1;
            restart_run   = RunOne;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        capture = 1'b0;
        err_evt = 1'b0;
        unique case (state_q)
            StHunt: begin
                if (count == 2'd0) begin
                    state_d = StAcq;
                    exp_d   = 2'd1;
                    run_d   = RunOne;
                end
            end
            StAcq: begin
                if (in_seq) begin
                    exp_d = next_phase(exp_q);
                    run_d = run_inc;
                    if (run_inc == LockRun) begin
                        state_d = StLocked;
                    end
                end else begin
                    state_d = restart_state;
                    exp_d   = restart_exp;
                    run_d   = restart_run;
                end
            end
            StLocked: begin
                if (in_seq) begin
                    exp_d   = next_phase(exp_q);
                    capture = (count == CapPhase);
                end else begin
                    err_evt = 1'b1;
                    state_d = restart_state;
                    exp_d   = restart_exp;
                    run_d   = restart_run;
                end
            end
            default: begin
                state_d = StHunt;
                exp_d   = 2'd0;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            exp_q       <= 2'd0;
            run_q       <= '0;
            y_out_q     <= '0;
            y_valid_q   <= 1'b0;
            locked_q    <= 1'b0;
            phase_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            locked_q    <= (state_d == StLocked);
            phase_err_q <= err_evt;
            y_valid_q   <= capture;
            if (capture) begin
                y_out_q <= din;
            end
            if (err_evt && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign y_out     = y_out_q;
    assign y_valid   = y_valid_q;
    assign locked    = locked_q;
    assign phase_err = phase_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fold_output_collector.sv
// Directed bench for fold_output_collector with a capture scoreboard.
module tb_fold_output_collector;

    localparam int DW = 16;
    localparam logic [DW-1:0] Neg5 = DW'(-5);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    count;
    logic [DW-1:0] din;
    logic [DW-1:0] y_out;
    logic          y_valid;
    logic          locked;
    logic          phase_err;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sb[$];

    fold_output_collector #(
        .DW(DW),
        .CAPTURE_PHASE(2),
        .LOCK_CNT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .count(count),
        .din(din),
        .y_out(y_out),
        .y_valid(y_valid),
        .locked(locked),
        .phase_err(phase_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, check just after the rising edge.
    task automatic step(input logic [1:0] c, input logic [DW-1:0] d, input bit cap);
        @(negedge clk);
        count = c;
        din   = d;
        if (cap) sb.push_back(d);
        @(posedge clk);
        #1;
        chk("y_valid", 32'(y_valid), 32'(cap));
        if (y_valid) begin
            chk("sb_pending", 32'(sb.size()), 32'(1));
            if (sb.size() > 0) chk("y_out", 32'(y_out), 32'(sb.pop_front()));
        end else if (cap && sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        count = 2'd0;
        din   = '0;
        step(2'd0, '0, 0);
        step(2'd0, '0, 0);
        chk("rst_y_out", 32'(y_out), 32'(0));
        chk("rst_locked", 32'(locked), 32'(0));
        chk("rst_phase_err", 32'(phase_err), 32'(0));
        chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        rst = 1'b0;

        // Acquire and first capture
        step(2'd0, DW'(1), 0);
        step(2'd1, DW'(2), 0);
        chk("acq_locked_lo", 32'(locked), 32'(0));
        step(2'd2, DW'(3), 0);
        chk("acq_locked_hi", 32'(locked), 32'(1));
        step(2'd0, DW'(4), 0);
        step(2'd1, DW'(5), 0);
        step(2'd2, DW'(6), 1);
        chk("first_y_out", 32'(y_out), 32'(6));

        // Steady lock, negative samples
        for (int i = 0; i < 30; i++) begin
            logic [1:0] c;
            c = 2'(i % 3);
            step(c, (c == 2'd2) ? Neg5 : DW'(i), c == 2'd2);
        end
        chk("steady_y_out", 32'(y_out), 32'(Neg5));
        chk("steady_err_cnt", 32'(err_cnt), 32'(0));
        chk("steady_locked", 32'(locked), 32'(1));

        // 0,1,0 while locked: error, restart into ACQ, relock after 1,2
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        step(2'd0, '0, 0);
        chk("r029_phase_err", 32'(phase_err), 32'(1));
        chk("r029_err_cnt", 32'(err_cnt), 32'(1));
        chk("r029_locked", 32'(locked), 32'(0));
        step(2'd1, '0, 0);
        chk("r029_pulse_end", 32'(phase_err), 32'(0));
        chk("r029_acq", 32'(locked), 32'(0));
        step(2'd2, DW'(50), 0);
        chk("r029_relock", 32'(locked), 32'(1));
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        step(2'd2, DW'(77), 1);

        // count==3 while locked drops to HUNT
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        step(2'd3, DW'(11), 0);
        chk("r030_phase_err", 32'(phase_err), 32'(1));
        chk("r030_err_cnt", 32'(err_cnt), 32'(2));
        chk("r030_locked", 32'(locked), 32'(0));
        step(2'd2, DW'(12), 0);
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        step(2'd2, DW'(13), 0);
        chk("r030_relock", 32'(locked), 32'(1));
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        step(2'd2, DW'(33), 1);

        // Out-of-sequence phase 2 while locked: error, no capture
        step(2'd2, DW'(99), 0);
        chk("mis2_phase_err", 32'(phase_err), 32'(1));
        chk("mis2_err_cnt", 32'(err_cnt), 32'(3));
        chk("mis2_y_out_hold", 32'(y_out), 32'(33));
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        step(2'd2, '0, 0);
        chk("mis2_relock", 32'(locked), 32'(1));

        // 300 violations: err_cnt saturates
        for (int i = 0; i < 300; i++) begin
            step(2'd0, '0, 0);
            step(2'd0, '0, 0);
            step(2'd1, '0, 0);
            step(2'd2, '0, 0);
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'(255));
        chk("sat_locked", 32'(locked), 32'(1));
        step(2'd0, '0, 0);
        step(2'd0, '0, 0);
        chk("sat_pulse", 32'(phase_err), 32'(1));
        chk("sat_hold", 32'(err_cnt), 32'(255));
        step(2'd1, '0, 0);
        step(2'd2, '0, 0);

        // Reset on a pending capture cycle
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        rst = 1'b1;
        step(2'd2, DW'(55), 0);
        chk("rstcap_y_out", 32'(y_out), 32'(0));
        chk("rstcap_locked", 32'(locked), 32'(0));
        chk("rstcap_phase_err", 32'(phase_err), 32'(0));
        chk("rstcap_err_cnt", 32'(err_cnt), 32'(0));
        rst = 1'b0;
        step(2'd0, '0, 0);
        step(2'd1, '0, 0);
        chk("post_rst_unlocked", 32'(locked), 32'(0));

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fold_output_collector.md
FOLD_OUTPUT_COLLECTOR -- requirements
Module: fold_output_collector

Interface
REQ-001 SHALL have parameter DW, default 16, the datapath sample width in bits (signed).
REQ-002 SHALL have parameter CAPTURE_PHASE, default 2, the fold phase on which din carries a completed output sample.
REQ-003 SHALL have parameter LOCK_CNT, default 3, the number of consecutive in-sequence phases required to declare lock.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port count, input, 2 bits: fold phase from the folding-phase counter; legal sequence 0,1,2,0,...
REQ-007 SHALL have port din, input, DW bits: folded datapath output, signed.
REQ-008 SHALL have port y_out, output, DW bits: last captured output sample, registered.
REQ-009 SHALL have port y_valid, output, 1 bit: one-cycle pulse marking a new y_out.
REQ-010 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-011 SHALL have port phase_err, output, 1 bit: one-cycle pulse on a sequence violation while locked.
REQ-012 SHALL have port err_cnt, output, 8 bits: saturating count of phase_err events.

Function
REQ-013 SHALL implement a three-state FSM: HUNT, ACQ, LOCKED; it SHALL also hold an expected-phase register exp (2 bits) and a run counter run.
REQ-014 In HUNT, count==0 SHALL move the FSM to ACQ with run=1 and exp=1; any other count SHALL keep it in HUNT.
REQ-015 In ACQ, count==exp SHALL increment run and advance exp (0->1->2->0); when the incremented run equals LOCK_CNT, the FSM SHALL move to LOCKED.
REQ-016 In ACQ, count!=exp SHALL restart acquisition: count==0 gives ACQ with run=1 and exp=1; otherwise the FSM SHALL return to HUNT.
REQ-017 In LOCKED, count==exp SHALL advance exp; count!=exp SHALL pulse phase_err on the next cycle and re-enter acquisition per REQ-016.
REQ-018 count==3 SHALL always be treated as a mismatch.
REQ-019 Capture: when the FSM is in LOCKED, count==exp and count==CAPTURE_PHASE, the next edge SHALL load y_out<=din and assert y_valid for exactly one cycle (latency 1 clk).
REQ-020 No capture SHALL occur in HUNT or ACQ, nor on the mismatching cycle itself.
REQ-021 y_out SHALL hold its value between captures; y_valid SHALL be 0 on all non-capture cycles.
REQ-022 locked SHALL be a registered decode of the state, updating on the same edge as the state transition.
REQ-023 err_cnt SHALL increment by 1 with each phase_err pulse and saturate at 255; it SHALL not wrap.
REQ-024 If phase_err and a lock-restart (count==0) occur on the same mismatch, both SHALL happen: the pulse, the increment, and the entry into ACQ.

Reset
REQ-025 rst=1 at a rising edge SHALL force: state=HUNT, exp=0, run=0, y_out=0, y_valid=0, locked=0, phase_err=0, err_cnt=0.
REQ-026 rst SHALL take priority over all other inputs, including mid-acquisition and mid-capture; a capture pending on that edge SHALL be discarded.

Verification
REQ-027 Release rst, drive count 0,1,2,0,1,2 with din=index (1..6) -> locked rises after edge 3; y_valid pulses once after edge 6 with y_out=6.
REQ-028 Steady locked sequence over 30 cycles with din=-5 at every phase-2 cycle -> y_valid pulses every 3rd cycle, y_out=-5 (two's complement), err_cnt=0.
REQ-029 While locked, inject count 0,1,0 -> phase_err pulse and err_cnt=1 after the second 0; locked drops; ACQ restarts; relock after 1,2.
REQ-030 While locked, inject count=3 -> phase_err pulse, FSM in HUNT, no y_valid until 3 more in-sequence phases from 0 followed by a phase 2.
REQ-031 Force 300 phase violations -> err_cnt stops at 255.
REQ-032 Assert rst on the cycle where count==2 while locked -> no y_valid, all outputs 0 on the next cycle.
